bmp_pixel_packer: RTL and testbench
===================================

Name: bmp_pixel_packer

Overview:
- Upstream feeder for the labelling top level.
- Accepts the raw 8-bit BMP pixel-data byte stream, including per-row padding, after the header has been stripped.
- Assembles little-endian BGR bytes into 24-bit pixels and drops row padding.
- Drives pixel data, hsync and vsync into the labelling pipeline, with a valid/ready handshake on both sides.

Parameters:
PIXEL_SIZE, 24, output pixel width; always 3 bytes.
BYTE_SIZE, 8, input byte width.
DIM_W, 12, width of the width/height dimension inputs and of the internal row/column counters.

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-high
en  in  1  global enable; when 0 all state is frozen
start  in  1  single-cycle pulse that begins a frame; sampled only in IDLE
width  in  DIM_W  pixels per row; latched on start
height  in  DIM_W  rows per frame; latched on start
padding  in  2  padding bytes per row (0-3); latched on start
byte_valid  in  1  input byte present
byte_data  in  BYTE_SIZE  input byte
byte_ready  out  1  byte accepted when byte_valid && byte_ready
pix_valid  out  1  output pixel present
pix_ready  in  1  downstream accepts the pixel
data  out  PIXEL_SIZE  {byte2, byte1, byte0}
hsync  out  1  high with the pixel at column 0
vsync  out  1  high with the pixel at row 0, column 0
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at the end of a frame
err  out  1  stray-byte flag; see Optional Feature

Behaviour:
- Reset values: every output is 0, the state is IDLE, and all counters and latches are 0.
- States:
  - IDLE: on start && en, latch width/height/padding and go to PIXEL. If width==0 or height==0, go to DONE instead.
  - PIXEL: accept bytes. A byte index (0..2) places each byte: byte0 → data[7:0], byte1 → [15:8], byte2 → [23:16]. On acceptance of byte2, load the output register with pix_valid=1, hsync=(col==0), vsync=(col==0 && row==0), then advance col.
    - When col reaches width-1 at that acceptance: if padding!=0, go to PAD; else go to the row-end step.
  - PAD: accept and discard exactly `padding` bytes, then go to the row-end step.
  - Row-end step: col=0 and row++. If row==height-1 at the time of the step, go to DONE; otherwise go to PIXEL.
  - DONE: frame_done=1 for exactly one cycle, then go to IDLE. DONE does not wait for a pending output pixel to drain; the output register drains independently.
- Output register: a one-entry register.
  - It holds data/hsync/vsync/pix_valid stable while pix_valid && !pix_ready.
  - byte_ready = en && (state is PIXEL or PAD) && !(pix_valid && !pix_ready). Stalling is applied in PAD as well, which keeps the rule uniform.
  - A pixel may be loaded in the same cycle the previous one is taken (pix_ready=1); full rate is 1 pixel per 3 accepted bytes.
- Latency: pix_valid rises on the clock edge after byte2 is accepted (1 cycle).
- en=0: byte_ready=0; all registers hold, including pix_valid/data. start is ignored. Handshakes resume exactly where they stopped.
- start while busy: ignored.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A partially assembled pixel is discarded.
- The counters never wrap within a frame, because width and height are held constant after latching.

Optional Feature:
- Macro: STRAY_BYTE_ERR_EN.
- Defined: err is sticky. It sets when byte_valid=1 in IDLE or DONE with en=1, and clears on an accepted start. It is 0 after reset.
- Undefined: err is tied to 0. Stray bytes are never accepted (byte_ready=0) and are not flagged.

Decomposition:
- Shared package pixel_pkg holds:
  - PIXEL_SIZE, BYTE_SIZE and DIM_W constants;
  - the state enum type {IDLE, PIXEL, PAD, DONE};
  - a typedef pixel_t for the 24-bit pixel.
- One sub-module, pixel_out_reg: the one-entry output register with valid/ready, carrying {data, hsync, vsync}.

Test Plan:
- 2x2 frame, padding=2, bytes 0x01..0x10 streamed, pix_ready=1:
  - pixels emitted are 0x030201, 0x060504, 0x0B0A09, 0x0E0D0C;
  - bytes 07,08,0F,10 are dropped;
  - hsync on pixels 1 and 3, vsync on pixel 1 only;
  - frame_done pulses once.
- 3x1 frame, padding=3, with pix_ready held 0 for 5 cycles after the first pixel:
  - byte_ready=0 during the stall;
  - data holds 0x030201;
  - no byte is lost, and all 3 pixels arrive in order.
- width=0, height=4, start pulse: frame_done pulses 2 cycles after start, no pix_valid, busy high for 1 cycle.
- 4x1 frame with en dropped to 0 for 10 cycles after byte 5: the output is identical to the run with no en drop, with only the timing shifted by 10 cycles.
- reset asserted after 2 pixels of a 4x2 frame:
  - all outputs 0 asynchronously, state IDLE;
  - a new start then delivers a fresh frame with vsync on its first pixel.
- STRAY_BYTE_ERR_EN defined: byte_valid=1 in IDLE sets err=1, and err stays 1 until the next start. With the macro undefined, err stays 0.

Source files
------------

// File: rtl/bmp_pixel_packer_pkg.sv
// rtl/bmp_pixel_packer_pkg.sv - shared constants and types for the BMP pixel packer
//
// Package pixel_pkg:
//   PIXEL_SIZE / BYTE_SIZE / DIM_W : pixel width, input byte width, dimension width
//   state_t                        : frame sequencing states
//   pixel_t                        : one assembled 24-bit BGR pixel
//   pix_beat_t                     : pixel plus its hsync/vsync markers
package pixel_pkg;

    localparam int PIXEL_SIZE = 24;
    localparam int BYTE_SIZE  = 8;
    localparam int DIM_W      = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIXEL = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [PIXEL_SIZE-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   hsync;
        logic   vsync;
    } pix_beat_t;

endpackage

// File: rtl/bmp_pixel_packer_if.sv
// rtl/bmp_pixel_packer_if.sv - byte-in / pixel-out handshake bundle
//
// Signals:
//   byte_valid, byte_data, byte_ready : raw BMP byte stream into the packer
//   pix_valid, pix_ready, data,
//   hsync, vsync                      : assembled pixel stream out of the packer
// Modports:
//   master : the packer side (consumes bytes, produces pixels)
//   slave  : the environment side (produces bytes, consumes pixels)
interface bmp_pixel_packer_if;
    import pixel_pkg::*;

    logic                 byte_valid;
    logic [BYTE_SIZE-1:0] byte_data;
    logic                 byte_ready;
    logic                 pix_valid;
    logic                 pix_ready;
    pixel_t               data;
    logic                 hsync;
    logic                 vsync;

    modport master (
        input  byte_valid, byte_data, pix_ready,
        output byte_ready, pix_valid, data, hsync, vsync
    );

    modport slave (
        output byte_valid, byte_data, pix_ready,
        input  byte_ready, pix_valid, data, hsync, vsync
    );

endinterface

// File: rtl/bmp_pixel_packer_out_reg.sv
// rtl/bmp_pixel_packer_out_reg.sv - one-entry valid/ready output register
//
// Module pixel_out_reg:
//   clk, reset  : clock, asynchronous active-high reset
//   en          : global enable; 0 freezes the entry
//   load        : capture load_beat this cycle
//   load_beat   : {data, hsync, vsync} to capture
//   pix_ready   : downstream accepts the held beat
//   pix_valid   : entry occupied
//   beat        : held {data, hsync, vsync}
module pixel_out_reg
    import pixel_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  logic      load,
    input  pix_beat_t load_beat,
    input  logic      pix_ready,
    output logic      pix_valid,
    output pix_beat_t beat
);

    logic      valid_q, valid_d;
    pix_beat_t beat_q,  beat_d;

    // A load may coincide with the previous beat being taken, so load wins
    // over the drain and the entry simply stays full with the new beat.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (en) begin
            if (load) begin
                valid_d = 1'b1;
                beat_d  = load_beat;
            end else if (valid_q && pix_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign pix_valid = valid_q;
    assign beat      = beat_q;

endmodule

// File: rtl/bmp_pixel_packer.sv
// rtl/bmp_pixel_packer.sv - packs BMP BGR bytes into 24-bit pixels and drops row padding
//
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   en                     : global enable; 0 freezes all state
//   start                  : frame start pulse, sampled only in IDLE
//   width, height, padding : frame geometry, latched on start
//   bus (master)           : byte stream in, pixel stream out with hsync/vsync
//   busy                   : state is not IDLE
//   frame_done             : one-cycle pulse after the last row
//   err                    : sticky stray-byte flag
// Build option: STRAY_BYTE_ERR_EN enables err; otherwise err is tied low.
module bmp_pixel_packer
    import pixel_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic [1:0]       padding,
    bmp_pixel_packer_if.master bus,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    state_t               state_q,      state_d;
    logic [1:0]           byte_idx_q,   byte_idx_d;
    logic [1:0]           pad_cnt_q,    pad_cnt_d;
    logic [DIM_W-1:0]     col_q,        col_d;
    logic [DIM_W-1:0]     row_q,        row_d;
    logic [DIM_W-1:0]     width_q,      width_d;
    logic [DIM_W-1:0]     height_q,     height_d;
    logic [1:0]           padding_q,    padding_d;
    logic [BYTE_SIZE-1:0] byte0_q,      byte0_d;
    logic [BYTE_SIZE-1:0] byte1_q,      byte1_d;
    logic                 frame_done_q, frame_done_d;

    logic      out_valid;
    pix_beat_t out_beat;
    pix_beat_t load_beat;
    logic      load;
    logic      stall;
    logic      byte_ready;
    logic      accept;
    logic      row_end;

    // Backpressure is applied in PAD too so the ready rule is the same in
    // every byte-consuming state.
    assign stall      = out_valid && !bus.pix_ready;
    assign byte_ready = en && (state_q == PIXEL || state_q == PAD) && !stall;
    assign accept     = bus.byte_valid && byte_ready;

    always_comb begin
        load_beat.data  = {bus.byte_data, byte1_q, byte0_q};
        load_beat.hsync = (col_q == '0);
        load_beat.vsync = (col_q == '0) && (row_q == '0);
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        pad_cnt_d    = pad_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        width_d      = width_q;
        height_d     = height_q;
        padding_d    = padding_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        frame_done_d = frame_done_q;
        load         = 1'b0;
        row_end      = 1'b0;

        if (en) begin
            frame_done_d = (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        width_d    = width;
                        height_d   = height;
                        padding_d  = padding;
                        col_d      = '0;
                        row_d      = '0;
                        byte_idx_d = 2'd0;
                        pad_cnt_d  = 2'd0;
                        state_d    = (width == '0 || height == '0) ? DONE : PIXEL;
                    end
                end
                PIXEL: begin
                    if (accept) begin
                        case (byte_idx_q)
                            2'd0: begin
                                byte0_d    = bus.byte_data;
                                byte_idx_d = 2'd1;
                            end
                            2'd1: begin
                                byte1_d    = bus.byte_data;
                                byte_idx_d = 2'd2;
                            end
                            default: begin
                                load       = 1'b1;
                                byte_idx_d = 2'd0;
                                if (col_q == width_q - 1'b1) begin
                                    if (padding_q != 2'd0) begin
                                        state_d   = PAD;
                                        pad_cnt_d = 2'd0;
                                    end else begin
                                        row_end = 1'b1;
                                    end
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                PAD: begin
                    if (accept) begin
                        if (pad_cnt_q == padding_q - 2'd1) begin
                            row_end = 1'b1;
                        end else begin
                            pad_cnt_d = pad_cnt_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Row end is taken in the same cycle as the last pixel or pad byte.
            if (row_end) begin
                col_d   = '0;
                row_d   = row_q + 1'b1;
                state_d = (row_q == height_q - 1'b1) ? DONE : PIXEL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            pad_cnt_q    <= 2'd0;
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            padding_q    <= 2'd0;
            byte0_q      <= '0;
            byte1_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            pad_cnt_q    <= pad_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            width_q      <= width_d;
            height_q     <= height_d;
            padding_q    <= padding_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            frame_done_q <= frame_done_d;
        end
    end

    pixel_out_reg u_out (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .load_beat (load_beat),
        .pix_ready (bus.pix_ready),
        .pix_valid (out_valid),
        .beat      (out_beat)
    );

    assign bus.byte_ready = byte_ready;
    assign bus.pix_valid  = out_valid;
    assign bus.data       = out_beat.data;
    assign bus.hsync      = out_beat.hsync;
    assign bus.vsync      = out_beat.vsync;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;

`ifdef STRAY_BYTE_ERR_EN
    logic err_q, err_d;

    // A byte offered while no frame is active is flagged until the next start.
    always_comb begin
        err_d = err_q;
        if (en) begin
            if (state_q == IDLE && start) begin
                err_d = 1'b0;
            end
            if (bus.byte_valid && (state_q == IDLE || state_q == DONE)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bmp_pixel_packer.sv
// tb/tb_bmp_pixel_packer.sv - self-checking bench for bmp_pixel_packer
module tb_bmp_pixel_packer;
    import pixel_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] width = '0;
    logic [DIM_W-1:0] height = '0;
    logic [1:0]       padding = 2'd0;
    logic             busy, frame_done, err;
    logic             ready_mode = 1'b0;
    logic             ready_val = 1'b1;
    logic             rnd_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_start = 0;
    int fd_cnt = 0;
    int pv_cnt = 0;
    int last_ob = 0;
    logic [25:0] obs[$];
    int          obs_t[$];

    bmp_pixel_packer_if bus();
    assign bus.pix_ready = ready_mode ? rnd_ready : ready_val;

    bmp_pixel_packer dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .width      (width),
        .height     (height),
        .padding    (padding),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    // Transfers and pulses are sampled mid-cycle, where everything is stable.
    always @(negedge clk) begin
        if (en && bus.pix_valid && bus.pix_ready) begin
            obs.push_back({bus.hsync, bus.vsync, bus.data});
            obs_t.push_back(cyc - t_start);
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (bus.pix_valid) pv_cnt = pv_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        check({tag, "_data"}, 32'(bus.data), 0);
        check({tag, "_hsync"}, 32'(bus.hsync), 0);
        check({tag, "_vsync"}, 32'(bus.vsync), 0);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit gaps, input int drop_at);
        for (int i = 0; i < b.size(); i++) begin
            int t;
            if (gaps) repeat ($urandom_range(0, 2)) step;
            bus.byte_valid = 1'b1;
            bus.byte_data  = b[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.byte_ready && t < 500);
            if (t >= 500) begin
                check("byte_timeout", 0, 1);
                bus.byte_valid = 1'b0;
                return;
            end
            step;
            bus.byte_valid = 1'b0;
            if (i == drop_at) begin
                en = 1'b0;
                repeat (10) step;
                en = 1'b1;
            end
        end
    endtask

    task automatic stall_check;
        int t = 0;
        while (!bus.pix_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("stall_first_pixel_seen", 32'(t < 200), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_byte_ready", 32'(bus.byte_ready), 0);
            check("stall_data", 32'(bus.data), 32'h030201);
            check("stall_pix_valid", 32'(bus.pix_valid), 1);
        end
        @(posedge clk);
        #1 ready_val = 1'b1;
    endtask

    task automatic run_frame(input int w, input int h, input int p, input bit seq,
                             input bit gaps, input bit rnd, input bit stall, input int drop_at);
        logic [7:0]  bytes[$];
        logic [25:0] exp[$];
        logic [25:0] e;
        int ob, fb, k, n;
        n = (3 * w + p) * h;
        for (int i = 0; i < n; i++) bytes.push_back(seq ? 8'(i + 1) : 8'($urandom));
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e = {c == 0, r == 0 && c == 0, bytes[k + 2], bytes[k + 1], bytes[k]};
                exp.push_back(e);
                k += 3;
            end
            k += p;
        end
        ob = obs.size();
        fb = fd_cnt;
        width = DIM_W'(w);
        height = DIM_W'(h);
        padding = 2'(p);
        ready_mode = rnd;
        ready_val = !stall;
        start = 1'b1;
        t_start = cyc;
        step;
        start = 1'b0;
        fork
            send_bytes(bytes, gaps, drop_at);
            if (stall) stall_check();
        join
        for (int t = 0; t < 2000 && ((obs.size() - ob) < exp.size() || fd_cnt == fb); t++) step;
        repeat (4) step;
        check("n_pix", 32'(obs.size() - ob), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("pix%0d_%0dx%0d", i, w, h), 32'(obs[ob + i]), 32'(exp[i]));
        check("frame_done_count", 32'(fd_cnt - fb), 1);
        check("busy_after_frame", 32'(busy), 0);
        last_ob = ob;
    endtask

    initial begin
        int ob, fb, pb, lo;
        int ta[4];
        logic [7:0] part[$];

        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b1;
        step;

        // 2x2, padding 2, sequential bytes
        run_frame(2, 2, 2, 1, 0, 0, 0, -1);
        lo = last_ob;
        check("p0", 32'(obs[lo][23:0]), 32'h030201);
        check("p1", 32'(obs[lo + 1][23:0]), 32'h060504);
        check("p2", 32'(obs[lo + 2][23:0]), 32'h0B0A09);
        check("p3", 32'(obs[lo + 3][23:0]), 32'h0E0D0C);
        check("hsync_pattern", 32'({obs[lo][25], obs[lo + 1][25], obs[lo + 2][25], obs[lo + 3][25]}), 32'b1010);
        check("vsync_pattern", 32'({obs[lo][24], obs[lo + 1][24], obs[lo + 2][24], obs[lo + 3][24]}), 32'b1000);

        // 3x1, padding 3, downstream stalled on the first pixel
        run_frame(3, 1, 3, 1, 0, 0, 1, -1);

        // zero width frame
        ob = obs.size();
        fb = fd_cnt;
        pb = pv_cnt;
        ready_mode = 1'b0;
        ready_val = 1'b1;
        width = '0;
        height = DIM_W'(4);
        padding = 2'd0;
        start = 1'b1;
        step;
        start = 1'b0;
        @(negedge clk);
        check("w0_busy_c1", 32'(busy), 1);
        check("w0_fd_c1", 32'(frame_done), 0);
        @(negedge clk);
        check("w0_busy_c2", 32'(busy), 0);
        check("w0_fd_c2", 32'(frame_done), 1);
        @(negedge clk);
        check("w0_fd_c3", 32'(frame_done), 0);
        check("w0_no_pix_valid", 32'(pv_cnt - pb), 0);
        check("w0_fd_count", 32'(fd_cnt - fb), 1);
        step;

        // 4x1 reference run, then the same frame with en low for 10 cycles
        run_frame(4, 1, 0, 1, 0, 0, 0, -1);
        for (int i = 0; i < 4; i++) ta[i] = obs_t[last_ob + i];
        run_frame(4, 1, 0, 1, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("en_drop_shift%0d", i), 32'(obs_t[last_ob + i] - ta[i]), (i == 0) ? 0 : 10);

        // reset after two pixels of a 4x2 frame
        ob = obs.size();
        width = DIM_W'(4);
        height = DIM_W'(2);
        padding = 2'd0;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 8; i++) part.push_back(8'(8'h40 + i));
        send_bytes(part, 0, -1);
        for (int t = 0; t < 50 && (obs.size() - ob) < 2; t++) @(negedge clk);
        check("rst_two_pixels", 32'(obs.size() - ob), 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        step;
        run_frame(4, 2, 0, 0, 1, 1, 0, -1);
        check("post_reset_vsync", 32'(obs[last_ob][24]), 1);

        // stray byte while idle
        ready_mode = 1'b0;
        ready_val = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'hAA;
        @(negedge clk);
        check("stray_byte_ready", 32'(bus.byte_ready), 0);
        step;
        bus.byte_valid = 1'b0;
        repeat (3) step;
`ifdef STRAY_BYTE_ERR_EN
        check("err_set", 32'(err), 1);
        repeat (5) step;
        check("err_sticky", 32'(err), 1);
        run_frame(1, 1, 0, 0, 0, 0, 0, -1);
        check("err_cleared", 32'(err), 0);
`else
        check("err_disabled", 32'(err), 0);
`endif

        // randomized frames
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 3), 0, 1, 1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
